// File: rtl/altsyncram_pkg.sv
//------------------------------------------------------------------------------
// Module : altsyncram_pkg
// Brief  : Legal parameter values and a parameter-legality check shared by the
//          altsyncram storage primitives.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package altsyncram_pkg;

  // Legal string values for the mode parameters
  localparam string C_MODE_DUAL_PORT   = "DUAL_PORT";
  localparam string C_REG_CLOCK0       = "CLOCK0";
  localparam string C_REG_UNREGISTERED = "UNREGISTERED";
  localparam string C_RDW_OLD_DATA     = "OLD_DATA";

  // The string parameters are compared by the caller and folded into
  // strings_ok. The geometry must be identical on both ports and the word
  // count must fit the address width.
  function automatic bit altsyncram_params_ok(
    input bit strings_ok,
    input int width_a,
    input int width_b,
    input int widthad_a,
    input int widthad_b,
    input int numwords_a,
    input int numwords_b
  );
    return strings_ok &&
           (width_a > 0) && (width_a == width_b) &&
           (widthad_a > 0) && (widthad_a == widthad_b) &&
           (numwords_a > 0) && (numwords_a == numwords_b) &&
           (numwords_a <= (1 << widthad_a));
  endfunction

endpackage

`default_nettype wire

// File: rtl/altsyncram_sdp.sv
//------------------------------------------------------------------------------
// Module : altsyncram_sdp
// Brief  : Simple dual-port synchronous RAM, write port A, read port B, one
//          clock. Registered read address, optional output register, mixed-port
//          read-during-write returns the old contents.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module altsyncram_sdp
  import altsyncram_pkg::*;
#(
  parameter string operation_mode                     = "DUAL_PORT",
  parameter int    width_a                            = 64,
  parameter int    widthad_a                          = 5,
  parameter int    numwords_a                         = 32,
  parameter int    width_b                            = 64,
  parameter int    widthad_b                          = 5,
  parameter int    numwords_b                         = 32,
  parameter string rdcontrol_reg_b                    = "CLOCK0",
  parameter string address_reg_b                      = "CLOCK0",
  parameter string outdata_reg_b                      = "UNREGISTERED",
  parameter string read_during_write_mode_mixed_ports = "OLD_DATA"
) (
  input  logic                 clock0,
  input  logic                 reset_n,
  input  logic                 wren_a,
  input  logic [widthad_a-1:0] address_a,
  input  logic [width_a-1:0]   data_a,
  input  logic                 rden_b,
  input  logic [widthad_b-1:0] address_b,
  output logic [width_b-1:0]   q_b
);

  localparam bit c_out_reg = (outdata_reg_b == C_REG_CLOCK0);

  localparam bit c_strings_ok =
    (operation_mode == C_MODE_DUAL_PORT) &&
    (rdcontrol_reg_b == C_REG_CLOCK0) &&
    (address_reg_b == C_REG_CLOCK0) &&
    ((outdata_reg_b == C_REG_UNREGISTERED) || c_out_reg) &&
    (read_during_write_mode_mixed_ports == C_RDW_OLD_DATA);

  generate
    if (!altsyncram_params_ok(c_strings_ok, width_a, width_b, widthad_a,
                              widthad_b, numwords_a, numwords_b)) begin : g_param_check
      $error("altsyncram_sdp: illegal parameter combination");
    end
  endgenerate

  logic [width_a-1:0] r_mem [numwords_a];
  logic [width_a-1:0] r_rdata;

  // Write port: commits regardless of reset so wrappers can preload while in
  // reset; addresses past the last word are dropped.
  always_ff @(posedge clock0) begin
    if (wren_a && (int'(address_a) < numwords_a)) begin
      r_mem[address_a] <= data_a;
    end
  end

  // Read port: the address is captured and the array read on the same edge,
  // so a same-edge write to that word is not yet visible (old data). With
  // rden_b low the captured word is held.
  always_ff @(posedge clock0) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (rden_b) begin
      r_rdata <= (int'(address_b) < numwords_b) ? r_mem[address_b] : '0;
    end
  end

  generate
    if (c_out_reg) begin : g_out_reg
      logic [width_b-1:0] r_q;

      // Output stage loads every cycle, independent of rden_b
      always_ff @(posedge clock0) begin
        if (!reset_n) begin
          r_q <= '0;
        end else begin
          r_q <= r_rdata;
        end
      end

      assign q_b = r_q;
    end else begin : g_out_unreg
      assign q_b = r_rdata;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_altsyncram_sdp.sv
//------------------------------------------------------------------------------
// Module : tb_altsyncram_sdp
// Brief  : Directed and random checks of altsyncram_sdp in both output modes,
//          plus a reduced-depth instance for out-of-range addressing.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_altsyncram_sdp;

  logic        clock0 = 1'b0;
  logic        reset_n = 1'b0;
  logic        wren_a = 1'b0;
  logic [4:0]  address_a = '0;
  logic [63:0] data_a = '0;
  logic        rden_b = 1'b0;
  logic [4:0]  address_b = '0;
  logic [63:0] q_u, q_r, q_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock0 = ~clock0;

  altsyncram_sdp #(.outdata_reg_b("UNREGISTERED")) dut_u (
    .clock0(clock0), .reset_n(reset_n), .wren_a(wren_a), .address_a(address_a),
    .data_a(data_a), .rden_b(rden_b), .address_b(address_b), .q_b(q_u));

  altsyncram_sdp #(.outdata_reg_b("CLOCK0")) dut_r (
    .clock0(clock0), .reset_n(reset_n), .wren_a(wren_a), .address_a(address_a),
    .data_a(data_a), .rden_b(rden_b), .address_b(address_b), .q_b(q_r));

  altsyncram_sdp #(.numwords_a(24), .numwords_b(24),
                   .outdata_reg_b("UNREGISTERED")) dut_s (
    .clock0(clock0), .reset_n(reset_n), .wren_a(wren_a), .address_a(address_a),
    .data_a(data_a), .rden_b(rden_b), .address_b(address_b), .q_b(q_s));

  // Reference model used for the random phase
  bit [63:0] m_mem   [32];
  bit [63:0] m_mem_s [32];
  bit [63:0] m_ru, m_rs, m_q;

  // Model of the three instances, updated on the same edge as the DUTs
  always @(posedge clock0) begin
    if (!reset_n) begin
      m_ru <= '0;
      m_rs <= '0;
      m_q  <= '0;
    end else begin
      if (rden_b) begin
        m_ru <= m_mem[address_b];
        m_rs <= (address_b < 5'd24) ? m_mem_s[address_b] : 64'd0;
      end
      m_q <= m_ru;
    end
    if (wren_a) begin
      m_mem[address_a] <= data_a;
      if (address_a < 5'd24) m_mem_s[address_a] <= data_a;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then step to #1 after the next rising edge
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                     input logic re, input logic [4:0] ra);
    wren_a    = we;
    address_a = wa;
    data_a    = wd;
    rden_b    = re;
    address_b = ra;
    @(posedge clock0);
    #1;
  endtask

  initial begin
    // Preload every word while held in reset
    reset_n = 1'b0;
    @(posedge clock0);
    #1;
    for (int i = 0; i < 32; i++) cyc(1'b1, 5'(i), 64'h1000 + 64'(i), 1'b1, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd4);
    check("reset_q_unreg", q_u, 64'd0);
    check("reset_q_reg",   q_r, 64'd0);
    check("reset_q_small", q_s, 64'd0);
    reset_n = 1'b1;

    // Write then read, latency of each output mode
    cyc(1'b1, 5'd3, 64'hDEAD, 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd3);
    check("lat_unreg_1", q_u, 64'hDEAD);
    check("lat_reg_1",   q_r, 64'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    check("lat_reg_2",   q_r, 64'hDEAD);
    check("hold_unreg",  q_u, 64'hDEAD);

    // Mixed-port read-during-write returns old data
    cyc(1'b1, 5'd5, 64'h11, 1'b0, 5'd0);
    cyc(1'b1, 5'd5, 64'h22, 1'b1, 5'd5);
    check("rdw_old_unreg", q_u, 64'h11);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd5);
    check("rdw_new_unreg", q_u, 64'h22);
    check("rdw_old_reg",   q_r, 64'h11);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    check("rdw_new_reg",   q_r, 64'h22);

    // rden_b low holds the output, even while the held word is rewritten
    cyc(1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    check("rden_unreg_0", q_u, 64'h77);
    cyc(1'b1, 5'd7, 64'h99, 1'b0, 5'd9);
    check("rden_unreg_1", q_u, 64'h77);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd9);
    check("rden_unreg_2", q_u, 64'h77);
    check("rden_reg_2",   q_r, 64'h77);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd9);
    check("rden_unreg_3", q_u, 64'h77);
    check("rden_reg_3",   q_r, 64'h77);

    // Reset clears the read pipeline but not the memory
    cyc(1'b1, 5'd2, 64'hAB, 1'b0, 5'd0);
    reset_n = 1'b0;
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd2);
    check("rst1_unreg", q_u, 64'd0);
    check("rst1_reg",   q_r, 64'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd2);
    check("rst2_unreg", q_u, 64'd0);
    check("rst2_reg",   q_r, 64'd0);
    reset_n = 1'b1;
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd2);
    check("retain_unreg", q_u, 64'hAB);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    check("retain_reg",   q_r, 64'hAB);

    // Depth boundary on the 24-word instance
    cyc(1'b1, 5'd27, 64'h5A5A, 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd27);
    check("oob_full",  q_u, 64'h5A5A);
    check("oob_small", q_s, 64'd0);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd23);
    check("last_small", q_s, 64'h1017);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd31);
    check("top_full",  q_u, 64'h101F);
    check("top_small", q_s, 64'd0);

    // Random traffic against the model (model memory matches after preload
    // and the directed writes above, since it tracked the same inputs)
    for (int n = 0; n < 2000; n++) begin
      reset_n = ($urandom_range(49) != 0);
      cyc(1'($urandom_range(1)), 5'($urandom_range(31)), {$urandom, $urandom},
          1'($urandom_range(3) != 0), 5'($urandom_range(31)));
      check("rand_unreg", q_u, m_ru);
      check("rand_reg",   q_r, m_q);
      check("rand_small", q_s, m_rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
